// File: rtl/sbus_to_sram_wait_pkg.sv
// Shared definitions for sbus-to-SRAM bridges: bus widths, lane masks,
// FSM state encodings and the size/offset to lane-mask decoder.
package sbus_to_sram_wait_pkg;

  localparam int W_ADDR          = 32;
  localparam int W_DATA          = 32;
  localparam int SBUS_MAX_RD_LAT = 8;

  typedef logic [3:0] lane_t;

  // FSM encodings kept as plain constants for compatibility with older tools
  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_RWAIT = 1'b1;

  // Decode access size and byte offset into a byte-lane mask; 0 means misaligned
  function automatic lane_t size_to_lane(input logic [1:0] size, input logic [1:0] addr_lo);
    lane_t lane;
    lane = '0;
    case (size)
      2'b00: lane = lane_t'(4'b0001 << addr_lo);
      2'b01: begin
        if (addr_lo == 2'd0)      lane = 4'b0011;
        else if (addr_lo == 2'd2) lane = 4'b1100;
      end
      2'b10: begin
        if (addr_lo == 2'd0) lane = 4'b1111;
      end
      default: lane = '0;
    endcase
    return lane;
  endfunction

  // Index of the lowest enabled lane; an empty mask maps to lane 0
  function automatic logic [1:0] lane_low(input lane_t lane);
    logic [1:0] idx;
    idx = 2'd0;
    if (lane[0])      idx = 2'd0;
    else if (lane[1]) idx = 2'd1;
    else if (lane[2]) idx = 2'd2;
    else if (lane[3]) idx = 2'd3;
    return idx;
  endfunction

endpackage

// File: rtl/sbus_to_sram_wait_lane_align.sv
// Byte-lane alignment: lane mask generation, write data shift into lanes and
// read data extraction (masked to the access width, shifted down, zero-extended).
module sbus_lane_align
  import sbus_to_sram_wait_pkg::*;
(
  input  logic [1:0]        size_i,
  input  logic [1:0]        addr_lo_i,
  input  logic [W_DATA-1:0] wdata_i,
  input  lane_t             rd_lane_i,
  input  logic [W_DATA-1:0] rdata_i,
  output lane_t             lane_o,
  output logic [W_DATA-1:0] wdata_o,
  output logic [W_DATA-1:0] rdata_o
);

  logic [4:0]        wr_shift;
  logic [4:0]        rd_shift;
  logic [W_DATA-1:0] rd_masked;

  assign lane_o   = size_to_lane(size_i, addr_lo_i);
  assign wr_shift = {lane_low(lane_o), 3'b000};
  assign rd_shift = {lane_low(rd_lane_i), 3'b000};

  // Keep only the bytes of the captured access so narrow loads zero-extend
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_rd_mask
      assign rd_masked[gi*8 +: 8] = rdata_i[gi*8 +: 8] & {8{rd_lane_i[gi]}};
    end
  endgenerate

  assign wdata_o = wdata_i << wr_shift;
  assign rdata_o = rd_masked >> rd_shift;

endmodule

// File: rtl/sbus_to_sram_wait.sv
// sbus slave to synchronous SRAM bridge with RD_LAT-cycle read latency,
// stall generation while a read is in flight and misaligned-access rejection.
module sbus_to_sram_wait
  import sbus_to_sram_wait_pkg::*;
#(
  parameter int RD_LAT = 1,
  parameter int CNT_W  = $clog2(RD_LAT + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sbus_en,
  input  logic              sbus_we,
  input  logic [1:0]        sbus_size,
  input  logic [W_ADDR-1:0] sbus_addr,
  input  logic [W_DATA-1:0] sbus_data_w,
  output logic [W_DATA-1:0] sbus_data_r,
  output logic              sbus_stall,
  output logic              sram_en,
  output logic [3:0]        sram_we,
  output logic [W_ADDR-1:0] sram_addr,
  output logic [W_DATA-1:0] sram_wdata,
  input  logic [W_DATA-1:0] sram_rdata,
  output logic              misalign
);

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  lane_t            lane_q, lane_d;
  lane_t            req_lane;

  sbus_lane_align u_align (
    .size_i    (sbus_size),
    .addr_lo_i (sbus_addr[1:0]),
    .wdata_i   (sbus_data_w),
    .rd_lane_i (lane_q),
    .rdata_i   (sram_rdata),
    .lane_o    (req_lane),
    .wdata_o   (sram_wdata),
    .rdata_o   (sbus_data_r)
  );

  assign sram_addr = {sbus_addr[W_ADDR-1:2], 2'b00};

  // Request decode, wait counting and output drive; outputs held quiet in reset
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    lane_d     = lane_q;
    sbus_stall = 1'b0;
    sram_en    = 1'b0;
    sram_we    = 4'b0000;
    misalign   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (sbus_en) begin
          lane_d = req_lane;
          if (req_lane == 4'b0000) begin
            misalign = 1'b1;
          end else if (sbus_we) begin
            sram_en = 1'b1;
            sram_we = req_lane;
          end else begin
            sram_en = 1'b1;
            if (RD_LAT > 1) begin
              sbus_stall = 1'b1;
              cnt_d      = CNT_W'(RD_LAT - 1);
              state_d    = S_RWAIT;
            end
          end
        end
      end
      S_RWAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q > CNT_W'(1)) sbus_stall = 1'b1;
        else                   state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (!rst) begin
      sbus_stall = 1'b0;
      sram_en    = 1'b0;
      sram_we    = 4'b0000;
      misalign   = 1'b0;
    end
  end

  // State registers; reset discards any in-flight read
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      lane_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lane_q  <= lane_d;
    end
  end

endmodule

// File: tb/tb_sbus_to_sram_wait.sv
// Directed bench: four bridges (RD_LAT 1..4) share stimulus; each scenario
// checks the instance whose latency it targets.
module tb_sbus_to_sram_wait;

  logic        clk;
  logic        rst;
  logic        en;
  logic        we;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] data_w;
  logic [31:0] rdata;

  logic [31:0] data_r_w [4];
  logic        stall_w  [4];
  logic        sen_w    [4];
  logic [3:0]  swe_w    [4];
  logic [31:0] saddr_w  [4];
  logic [31:0] swdata_w [4];
  logic        mis_w    [4];

  int cmp_cnt = 0;
  int mis_cnt = 0;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_dut
      sbus_to_sram_wait #(.RD_LAT(gi + 1)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .sbus_en     (en),
        .sbus_we     (we),
        .sbus_size   (size),
        .sbus_addr   (addr),
        .sbus_data_w (data_w),
        .sbus_data_r (data_r_w[gi]),
        .sbus_stall  (stall_w[gi]),
        .sram_en     (sen_w[gi]),
        .sram_we     (swe_w[gi]),
        .sram_addr   (saddr_w[gi]),
        .sram_wdata  (swdata_w[gi]),
        .sram_rdata  (rdata),
        .misalign    (mis_w[gi])
      );
    end
  endgenerate

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic start_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    start_cycle();
    rst = 1'b0; en = 1'b0; we = 1'b0;
    start_cycle();
    start_cycle();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 1'b1; we = 1'b0; size = 2'b10; addr = 32'h100; rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      cmp_cnt++;
      if (stall_w[i] !== 1'b0 || sen_w[i] !== 1'b0 || swe_w[i] !== 4'b0 || mis_w[i] !== 1'b0) begin
        mis_cnt++;
        $display("FAIL reset_outputs dut%0d: got stall=%b en=%b we=%b mis=%b expected all 0", i, stall_w[i], sen_w[i], swe_w[i], mis_w[i]);
      end
      cmp_cnt++;
      if (data_r_w[i] !== 32'h0) begin
        mis_cnt++;
        $display("FAIL reset_data_r dut%0d: got %h expected 00000000", i, data_r_w[i]);
      end
    end
    $display("reset: outputs checked on all instances");
    do_reset();
  endtask

  task automatic test_read_lat1();
    start_cycle();
    en = 1'b1; we = 1'b0; size = 2'b10; addr = 32'h100;
    @(negedge clk);
    cmp_cnt++;
    if (stall_w[0] !== 1'b0 || sen_w[0] !== 1'b1 || swe_w[0] !== 4'b0 || saddr_w[0] !== 32'h100) begin
      mis_cnt++;
      $display("FAIL rd1_req: got stall=%b en=%b we=%b addr=%h expected 0 1 0000 00000100", stall_w[0], sen_w[0], swe_w[0], saddr_w[0]);
    end
    start_cycle();
    en = 1'b1; size = 2'b01; addr = 32'h202; rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    cmp_cnt++;
    if (data_r_w[0] !== 32'hDEAD_BEEF || stall_w[0] !== 1'b0) begin
      mis_cnt++;
      $display("FAIL rd1_lw_data: got %h stall=%b expected deadbeef stall=0", data_r_w[0], stall_w[0]);
    end
    $display("lw 0x100 lat1: data_r=%h", data_r_w[0]);
    start_cycle();
    en = 1'b0; rdata = 32'h5678_1234;
    @(negedge clk);
    cmp_cnt++;
    if (data_r_w[0] !== 32'h0000_5678) begin
      mis_cnt++;
      $display("FAIL rd1_lhu_data: got %h expected 00005678", data_r_w[0]);
    end
    $display("lhu 0x202 lat1: data_r=%h", data_r_w[0]);
    do_reset();
  endtask

  task automatic test_read_lat3();
    logic [1:0] exp_stall [3];
    logic [0:0] exp_en    [3];
    exp_stall = '{2'd1, 2'd1, 2'd0};
    exp_en    = '{1'b1, 1'b0, 1'b0};
    for (int c = 0; c < 3; c++) begin
      start_cycle();
      en = 1'b1; we = 1'b0; size = 2'b00; addr = 32'h103;
      @(negedge clk);
      cmp_cnt++;
      if ({1'b0, stall_w[2]} !== exp_stall[c] || sen_w[2] !== exp_en[c]) begin
        mis_cnt++;
        $display("FAIL rd3_cycle%0d: got stall=%b en=%b expected stall=%0d en=%b", c, stall_w[2], sen_w[2], exp_stall[c], exp_en[c]);
      end
    end
    start_cycle();
    en = 1'b0; rdata = 32'hAB00_0000;
    @(negedge clk);
    cmp_cnt++;
    if (data_r_w[2] !== 32'h0000_00AB) begin
      mis_cnt++;
      $display("FAIL rd3_data: got %h expected 000000ab", data_r_w[2]);
    end
    $display("lbu 0x103 lat3: data_r=%h", data_r_w[2]);
    do_reset();
  endtask

  task automatic test_write();
    start_cycle();
    en = 1'b1; we = 1'b1; size = 2'b01; addr = 32'h202; data_w = 32'h0000_1234;
    @(negedge clk);
    for (int i = 0; i < 4; i += 3) begin
      cmp_cnt++;
      if (swe_w[i] !== 4'b1100 || swdata_w[i] !== 32'h1234_0000 || saddr_w[i] !== 32'h200 ||
          stall_w[i] !== 1'b0 || sen_w[i] !== 1'b1) begin
        mis_cnt++;
        $display("FAIL sh_write dut%0d: got we=%b wdata=%h addr=%h stall=%b en=%b expected 1100 12340000 00000200 0 1",
                 i, swe_w[i], swdata_w[i], saddr_w[i], stall_w[i], sen_w[i]);
      end
    end
    $display("sh 0x202: sram_we=%b wdata=%h", swe_w[3], swdata_w[3]);
    start_cycle();
    en = 1'b1; we = 1'b1; size = 2'b00; addr = 32'h301; data_w = 32'h0000_00C5;
    @(negedge clk);
    cmp_cnt++;
    if (swe_w[3] !== 4'b0010 || swdata_w[3] !== 32'h0000_C500 || stall_w[3] !== 1'b0) begin
      mis_cnt++;
      $display("FAIL sb_write_b2b: got we=%b wdata=%h stall=%b expected 0010 0000c500 0", swe_w[3], swdata_w[3], stall_w[3]);
    end
    $display("sb 0x301: sram_we=%b wdata=%h", swe_w[3], swdata_w[3]);
    do_reset();
  endtask

  task automatic test_misalign();
    start_cycle();
    en = 1'b1; we = 1'b0; size = 2'b10; addr = 32'h101;
    @(negedge clk);
    cmp_cnt++;
    if (mis_w[3] !== 1'b1 || sen_w[3] !== 1'b0 || swe_w[3] !== 4'b0 || stall_w[3] !== 1'b0) begin
      mis_cnt++;
      $display("FAIL lw_misalign: got mis=%b en=%b we=%b stall=%b expected 1 0 0000 0", mis_w[3], sen_w[3], swe_w[3], stall_w[3]);
    end
    start_cycle();
    en = 1'b0; rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    cmp_cnt++;
    if (mis_w[3] !== 1'b0 || data_r_w[3] !== 32'h0) begin
      mis_cnt++;
      $display("FAIL misalign_after: got mis=%b data_r=%h expected 0 00000000", mis_w[3], data_r_w[3]);
    end
    $display("lw 0x101: misalign pulse seen, data_r=%h", data_r_w[3]);
    start_cycle();
    en = 1'b1; we = 1'b1; size = 2'b01; addr = 32'h201;
    @(negedge clk);
    cmp_cnt++;
    if (mis_w[0] !== 1'b1 || swe_w[0] !== 4'b0 || sen_w[0] !== 1'b0) begin
      mis_cnt++;
      $display("FAIL sh_misalign: got mis=%b we=%b en=%b expected 1 0000 0", mis_w[0], swe_w[0], sen_w[0]);
    end
    $display("sh 0x201: misalign=%b sram_we=%b", mis_w[0], swe_w[0]);
    do_reset();
  endtask

  task automatic test_reset_mid_read();
    start_cycle();
    en = 1'b1; we = 1'b0; size = 2'b10; addr = 32'h40;
    @(negedge clk);
    cmp_cnt++;
    if (stall_w[3] !== 1'b1) begin
      mis_cnt++;
      $display("FAIL rd4_stall_c0: got %b expected 1", stall_w[3]);
    end
    start_cycle();
    rst = 1'b0; rdata = 32'h1357_9BDF;
    @(negedge clk);
    cmp_cnt++;
    if (stall_w[3] !== 1'b0 || sen_w[3] !== 1'b0 || data_r_w[3] !== 32'h0) begin
      mis_cnt++;
      $display("FAIL rd4_mid_reset: got stall=%b en=%b data_r=%h expected 0 0 00000000", stall_w[3], sen_w[3], data_r_w[3]);
    end
    start_cycle();
    rst = 1'b1; en = 1'b1; we = 1'b1; size = 2'b10; addr = 32'h10; data_w = 32'hCAFE_F00D;
    @(negedge clk);
    cmp_cnt++;
    if (swe_w[3] !== 4'b1111 || sen_w[3] !== 1'b1 || stall_w[3] !== 1'b0 || saddr_w[3] !== 32'h10 || swdata_w[3] !== 32'hCAFE_F00D) begin
      mis_cnt++;
      $display("FAIL sw_after_reset: got we=%b en=%b stall=%b addr=%h wdata=%h expected 1111 1 0 00000010 cafef00d",
               swe_w[3], sen_w[3], stall_w[3], saddr_w[3], swdata_w[3]);
    end
    $display("reset mid-read then sw 0x10: sram_we=%b", swe_w[3]);
    do_reset();
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_data [3];
    int          en_pulses;
    exp_data  = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
    en_pulses = 0;
    for (int c = 0; c < 7; c++) begin
      start_cycle();
      en = (c < 6); we = 1'b0; size = 2'b10; addr = 32'(4 * (c / 2));
      if (c >= 2 && (c % 2) == 0) rdata = exp_data[c / 2 - 1];
      else                        rdata = 32'hFFFF_FFFF;
      @(negedge clk);
      if (sen_w[1] === 1'b1) en_pulses++;
      cmp_cnt++;
      if (sen_w[1] !== ((c % 2) == 0 && c < 6) || stall_w[1] !== ((c % 2) == 0 && c < 6)) begin
        mis_cnt++;
        $display("FAIL b2b_cycle%0d: got en=%b stall=%b expected %0d %0d", c, sen_w[1], stall_w[1],
                 ((c % 2) == 0 && c < 6), ((c % 2) == 0 && c < 6));
      end
      if (c >= 2 && (c % 2) == 0) begin
        cmp_cnt++;
        if (data_r_w[1] !== exp_data[c / 2 - 1]) begin
          mis_cnt++;
          $display("FAIL b2b_data%0d: got %h expected %h", c / 2 - 1, data_r_w[1], exp_data[c / 2 - 1]);
        end
        $display("b2b lw %0d lat2: data_r=%h", c / 2 - 1, data_r_w[1]);
      end
    end
    cmp_cnt++;
    if (en_pulses != 3) begin
      mis_cnt++;
      $display("FAIL b2b_en_pulses: got %0d expected 3", en_pulses);
    end
    do_reset();
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; we = 1'b0; size = 2'b00; addr = '0; data_w = '0; rdata = '0;
    test_reset();
    test_read_lat1();
    test_read_lat3();
    test_write();
    test_misalign();
    test_reset_mid_read();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mis_cnt);
    $finish;
  end

endmodule
